// File: rtl/serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_digit_adder
// Description : Digit-serial adder with carry-in. Adds two WIDTH-bit operands
//               plus a carry-in, DIGIT bits per clock, through a registered
//               carry. One operation takes N = WIDTH/DIGIT RUN cycles.
//               Valid/ready handshake on both the operand and result sides.
// Parameters  : WIDTH (>=1) operand/sum width, DIGIT bits per cycle
//               (must divide WIDTH).
// Ports       : clk, rst (sync, active-high)
//               in_valid/in_ready, a, b, cin        operand side
//               out_valid/out_ready, sum, cout      result side
//               busy                                high in RUN or DONE
//               ovf (only with SERIAL_DIGIT_ADDER_OVF_EN) signed overflow
// Options     : `define SERIAL_DIGIT_ADDER_OVF_EN to add the ovf output.
// Revision    : 1.0  initial release
// ============================================================================
module serial_digit_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    // Counter needs at least one bit even when a whole operation is one digit.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    c_LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] c_MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic              w_accept;
    logic              w_last;
    logic [31:0]       w_lsb;
    logic [DIGIT-1:0]  w_a_dig;
    logic [DIGIT-1:0]  w_b_dig;
    logic [DIGIT:0]    w_add;
    logic [WIDTH-1:0]  w_sum_upd;

    // ------------------------------------------------------------------------
    // Handshake / status
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    // ------------------------------------------------------------------------
    // Digit slice and adder. Shifts are used instead of variable part-selects
    // so the digit position can be a plain runtime value.
    // ------------------------------------------------------------------------
    assign w_last    = (r_cnt == c_LAST);
    assign w_lsb     = 32'(r_cnt) * DIGIT;
    assign w_a_dig   = DIGIT'(r_a >> w_lsb);
    assign w_b_dig   = DIGIT'(r_b >> w_lsb);
    assign w_add     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    // Replace only digit k of the running sum; other bits keep their values.
    assign w_sum_upd = (r_sum & ~(c_MASK << w_lsb))
                     | (WIDTH'(w_add[DIGIT-1:0]) << w_lsb);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_upd;
                    r_carry <= w_add[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_add[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_DIGIT_ADDER_OVF_EN
    logic r_ovf;
    logic w_c_into_msb;

    // Carry into the MSB recovered from the MSB's own inputs and result bit.
    assign w_c_into_msb = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_add[DIGIT-1];
    assign ovf          = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_c_into_msb ^ w_add[DIGIT];
        end
    end
`endif

endmodule
`default_nettype wire
